ifetch: RTL and testbench

- Instruction fetch unit; the producer end of the decode stage's i_val/i_in/i_pc interface.
- Generates sequential PCs and issues word requests on the core-local instruction bus. Buffers responses in an in-order slot ring and presents one instruction per handshake to decode.
- Handles redirects (branch/jump/mret/trap) by flushing in-flight fetches.

---
 rtl/ifetch.sv | 135 +++++++++++++
 tb/tb_ifetch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch unit: issues sequential word fetches, buffers responses in an
// in-order slot ring and hands one instruction per handshake to decode.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_req_val,
  input  logic        i_req_rdy,
  output logic [31:0] o_req_addr,
  input  logic        i_rsp_val,
  input  logic [31:0] i_rsp_data,
  input  logic        i_rsp_err,
  output logic        o_val,
  output logic [31:0] o_in,
  output logic [31:0] o_pc,
  output logic        o_ferr,
  input  logic        i_rdy,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc
);

  // state | meaning
  // BOOT  | first cycle after reset, no request issued
  // RUN   | normal sequential issue
  // DRAIN | discarding responses that belong to a flushed stream
  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  state_t            r_state;
  logic [31:0]       r_addr;
  logic [31:0]       r_pc   [DEPTH];
  logic [31:0]       r_data [DEPTH];
  logic [DEPTH-1:0]  r_err;
  logic [DEPTH-1:0]  r_filled;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [PW-1:0]     r_fptr;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     r_ucnt;
  logic [CW-1:0]     r_drop;

  logic              w_pop;
  logic              w_alloc;
  logic              w_fill;
  logic [CW-1:0]     w_cnt_eff;
  logic [CW-1:0]     w_drop_base;
  logic              w_rsp_drop;
  logic [CW-1:0]     w_drop_new;
  logic              w_unused_flush_lsb;

  assign w_unused_flush_lsb = ^i_flush_pc[1:0];

  assign o_val  = r_filled[r_head];
  assign o_in   = r_data[r_head];
  assign o_pc   = r_pc[r_head];
  assign o_ferr = r_err[r_head];

  assign w_pop     = o_val & i_rdy & ~i_flush;
  assign w_cnt_eff = r_cnt - {{PW{1'b0}}, w_pop};
  // A pop frees its slot in time for a same-cycle request, giving 1/cycle throughput.
  assign o_req_val  = (r_state == RUN) & ~i_flush & (w_cnt_eff < CW'(DEPTH));
  assign o_req_addr = r_addr;
  assign w_alloc    = o_req_val & i_req_rdy;
  assign w_fill     = i_rsp_val & (r_state != DRAIN) & (r_ucnt != '0);

  // A response landing in the flush cycle retires one of the in-flight fetches.
  assign w_drop_base = (r_state == DRAIN) ? r_drop : r_ucnt;
  assign w_rsp_drop  = i_rsp_val & (w_drop_base != '0);
  assign w_drop_new  = w_drop_base - {{PW{1'b0}}, w_rsp_drop};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= BOOT;
      r_addr   <= RESET_PC;
      r_head   <= '0;
      r_tail   <= '0;
      r_fptr   <= '0;
      r_cnt    <= '0;
      r_ucnt   <= '0;
      r_drop   <= '0;
      r_filled <= '0;
      r_err    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_data[i] <= '0;
      end
    end else if (i_flush) begin
      r_addr   <= {i_flush_pc[31:2], 2'b00};
      r_head   <= '0;
      r_tail   <= '0;
      r_fptr   <= '0;
      r_cnt    <= '0;
      r_ucnt   <= '0;
      r_filled <= '0;
      r_drop   <= w_drop_new;
      r_state  <= (w_drop_new != '0) ? DRAIN : RUN;
    end else begin
      case (r_state)
        BOOT: r_state <= RUN;
        DRAIN: begin
          if (r_drop == '0 || (i_rsp_val && r_drop == CW'(1)))
            r_state <= RUN;
          if (i_rsp_val && r_drop != '0)
            r_drop <= r_drop - CW'(1);
        end
        default: r_state <= r_state;
      endcase

      if (w_pop) begin
        r_filled[r_head] <= 1'b0;
        r_head           <= r_head + PW'(1);
      end
      if (w_fill) begin
        r_data[r_fptr]   <= i_rsp_err ? 32'h0000_0000 : i_rsp_data;
        r_err[r_fptr]    <= i_rsp_err;
        r_filled[r_fptr] <= 1'b1;
        r_fptr           <= r_fptr + PW'(1);
      end
      // Allocation is last so it wins over a pop of the same slot.
      if (w_alloc) begin
        r_pc[r_tail]     <= r_addr;
        r_filled[r_tail] <= 1'b0;
        r_tail           <= r_tail + PW'(1);
        r_addr           <= r_addr + 32'd4;
      end
      r_cnt  <= r_cnt + {{PW{1'b0}}, w_alloc} - {{PW{1'b0}}, w_pop};
      r_ucnt <= r_ucnt + {{PW{1'b0}}, w_alloc} - {{PW{1'b0}}, w_fill};
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a latency-programmable in-order bus model plus
// per-scenario tasks with hand-computed expectations.
module tb_ifetch;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_req_val;
  logic        i_req_rdy = 1'b1;
  logic [31:0] o_req_addr;
  logic        i_rsp_val = 1'b0;
  logic [31:0] i_rsp_data = '0;
  logic        i_rsp_err = 1'b0;
  logic        o_val;
  logic [31:0] o_in;
  logic [31:0] o_pc;
  logic        o_ferr;
  logic        i_rdy = 1'b1;
  logic        i_flush = 1'b0;
  logic [31:0] i_flush_pc = '0;

  ifetch dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_req_val(o_req_val), .i_req_rdy(i_req_rdy), .o_req_addr(o_req_addr),
    .i_rsp_val(i_rsp_val), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .o_val(o_val), .o_in(o_in), .o_pc(o_pc), .o_ferr(o_ferr),
    .i_rdy(i_rdy), .i_flush(i_flush), .i_flush_pc(i_flush_pc)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  logic [31:0] err_addr = 32'h0000_0001;

  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  logic [31:0] del_pc[$];
  logic [31:0] del_in[$];
  logic        del_err[$];
  int          del_cyc[$];
  int          rsp_cyc[$];

  logic        obs_req_val, obs_val, obs_ferr;
  logic [31:0] obs_req_addr, obs_in, obs_pc;

  // Memory content: each word is the bitwise inverse of its address.
  task automatic step();
    logic [31:0] a;
    @(negedge i_clk);
    i_rsp_val = 1'b0; i_rsp_data = '0; i_rsp_err = 1'b0;
    if (!i_rst && q_addr.size() > 0 && q_due[0] <= cyc) begin
      a = q_addr.pop_front();
      void'(q_due.pop_front());
      i_rsp_val  = 1'b1;
      i_rsp_err  = (a == err_addr);
      i_rsp_data = (a == err_addr) ? 32'hDEAD_BEEF : ~a;
      rsp_cyc.push_back(cyc);
    end
    #1;
    obs_req_val = o_req_val; obs_req_addr = o_req_addr;
    obs_val = o_val; obs_in = o_in; obs_pc = o_pc; obs_ferr = o_ferr;
    if (!i_rst && o_req_val && i_req_rdy) begin
      acc_addr.push_back(o_req_addr); acc_cyc.push_back(cyc);
      q_addr.push_back(o_req_addr);   q_due.push_back(cyc + lat);
    end
    if (!i_rst && o_val && i_rdy && !i_flush) begin
      del_pc.push_back(o_pc); del_in.push_back(o_in);
      del_err.push_back(o_ferr); del_cyc.push_back(cyc);
    end
    @(posedge i_clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int l, input logic rdy);
    lat = l; i_rdy = rdy; i_flush = 1'b0; i_rst = 1'b1;
    step(); step();
    i_rst = 1'b0;
    q_addr.delete(); q_due.delete(); acc_addr.delete(); acc_cyc.delete();
    del_pc.delete(); del_in.delete(); del_err.delete(); del_cyc.delete(); rsp_cyc.delete();
  endtask

  task automatic wait_del(input int n, input string name);
    for (int k = 0; k < 60 && del_pc.size() < n; k++) step();
    total++;
    if (del_pc.size() < n) begin
      bad++; $display("FAIL %s timeout: delivered=%0d required=%0d", name, del_pc.size(), n);
    end
  endtask

  task automatic wait_acc(input int n, input string name);
    for (int k = 0; k < 60 && acc_addr.size() < n; k++) step();
    total++;
    if (acc_addr.size() < n) begin
      bad++; $display("FAIL %s timeout: accepted=%0d required=%0d", name, acc_addr.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset(1, 1'b1);
    step();
    total++; if (obs_req_val !== 1'b0) begin bad++; $display("FAIL rst_req_val got=%b exp=0", obs_req_val); end
    total++; if (obs_req_addr !== 32'h8000_0000) begin bad++; $display("FAIL rst_req_addr got=%h exp=80000000", obs_req_addr); end
    total++; if (obs_val !== 1'b0) begin bad++; $display("FAIL rst_val got=%b exp=0", obs_val); end
    total++; if (obs_in !== 32'h0) begin bad++; $display("FAIL rst_in got=%h exp=0", obs_in); end
    total++; if (obs_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", obs_pc); end
    total++; if (obs_ferr !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b exp=0", obs_ferr); end
    step();
    total++; if (obs_req_val !== 1'b1 || obs_req_addr !== 32'h8000_0000) begin
      bad++; $display("FAIL first_req got=%b/%h exp=1/80000000", obs_req_val, obs_req_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    exp_pc = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    exp_in = '{32'h7FFF_FFFF, 32'h7FFF_FFFB, 32'h7FFF_FFF7};
    do_reset(1, 1'b1);
    wait_del(3, "stream");
    if (del_pc.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        total++; if (del_pc[i] !== exp_pc[i] || del_in[i] !== exp_in[i]) begin
          bad++; $display("FAIL stream_%0d got=%h/%h exp=%h/%h", i, del_pc[i], del_in[i], exp_pc[i], exp_in[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        total++; if (del_cyc[i] != del_cyc[i-1] + 1) begin
          bad++; $display("FAIL stream_gap_%0d got=%0d exp=%0d", i, del_cyc[i], del_cyc[i-1] + 1);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
    do_reset(1, 1'b0);
    step(); step(); step();
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if (obs_val !== 1'b1 || obs_pc !== 32'h8000_0000 || obs_in !== 32'h7FFF_FFFF) begin
        bad++; $display("FAIL stall_hold_%0d got=%b/%h/%h exp=1/80000000/7fffffff", k, obs_val, obs_pc, obs_in);
      end
    end
    total++; if (acc_addr.size() != 2) begin
      bad++; $display("FAIL stall_reqs got=%0d exp=2", acc_addr.size());
    end
    i_rdy = 1'b1;
    wait_del(4, "stall_resume");
    if (del_pc.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        total++; if (del_pc[i] !== exp_pc[i] || del_in[i] !== ~exp_pc[i]) begin
          bad++; $display("FAIL stall_order_%0d got=%h/%h exp=%h/%h", i, del_pc[i], del_in[i], exp_pc[i], ~exp_pc[i]);
        end
      end
    end
  endtask

  task automatic test_flush_drain();
    do_reset(3, 1'b1);
    step(); step(); step();
    total++; if (acc_addr.size() != 2) begin
      bad++; $display("FAIL drain_setup got=%0d exp=2", acc_addr.size());
    end
    i_flush = 1'b1; i_flush_pc = 32'h0000_0102;
    step();
    total++; if (obs_req_val !== 1'b0) begin bad++; $display("FAIL drain_flush_req got=%b exp=0", obs_req_val); end
    i_flush = 1'b0;
    step();
    total++; if (obs_req_val !== 1'b0 || obs_req_addr !== 32'h0000_0100 || obs_val !== 1'b0) begin
      bad++; $display("FAIL drain_retarget got=%b/%h/%b exp=0/00000100/0", obs_req_val, obs_req_addr, obs_val);
    end
    wait_acc(3, "drain_newreq");
    if (acc_addr.size() >= 3) begin
      total++; if (acc_addr[2] !== 32'h0000_0100) begin
        bad++; $display("FAIL drain_addr got=%h exp=00000100", acc_addr[2]);
      end
      total++; if (rsp_cyc.size() < 2 || acc_cyc[2] <= rsp_cyc[1]) begin
        bad++; $display("FAIL drain_early_req got_cycle=%0d exp_after=%0d", acc_cyc[2], (rsp_cyc.size() >= 2) ? rsp_cyc[1] : -1);
      end
    end
    wait_del(1, "drain_deliver");
    if (del_pc.size() >= 1) begin
      total++; if (del_pc[0] !== 32'h0000_0100 || del_in[0] !== 32'hFFFF_FEFF) begin
        bad++; $display("FAIL drain_first got=%h/%h exp=00000100/fffffeff", del_pc[0], del_in[0]);
      end
    end
  endtask

  task automatic test_flush_collide();
    int n;
    do_reset(1, 1'b1);
    wait_del(2, "collide_setup");
    i_flush = 1'b1; i_flush_pc = 32'h0000_0200;
    step();
    total++; if (obs_val !== 1'b1 || i_rsp_val !== 1'b1 || obs_req_val !== 1'b0) begin
      bad++; $display("FAIL collide_cycle got val=%b rsp=%b req=%b exp=1/1/0", obs_val, i_rsp_val, obs_req_val);
    end
    n = del_pc.size();
    i_flush = 1'b0;
    step();
    total++; if (obs_req_val !== 1'b1 || obs_req_addr !== 32'h0000_0200 || obs_val !== 1'b0) begin
      bad++; $display("FAIL collide_next got=%b/%h/%b exp=1/00000200/0", obs_req_val, obs_req_addr, obs_val);
    end
    wait_del(n + 1, "collide_deliver");
    if (del_pc.size() > n) begin
      total++; if (del_pc[n] !== 32'h0000_0200 || del_in[n] !== 32'hFFFF_FDFF) begin
        bad++; $display("FAIL collide_first got=%h/%h exp=00000200/fffffdff", del_pc[n], del_in[n]);
      end
    end
  endtask

  task automatic test_err();
    err_addr = 32'h8000_0004;
    do_reset(1, 1'b1);
    wait_del(3, "err");
    if (del_pc.size() >= 3) begin
      total++; if (del_pc[0] !== 32'h8000_0000 || del_in[0] !== 32'h7FFF_FFFF || del_err[0] !== 1'b0) begin
        bad++; $display("FAIL err_before got=%h/%h/%b exp=80000000/7fffffff/0", del_pc[0], del_in[0], del_err[0]);
      end
      total++; if (del_pc[1] !== 32'h8000_0004 || del_in[1] !== 32'h0 || del_err[1] !== 1'b1) begin
        bad++; $display("FAIL err_fault got=%h/%h/%b exp=80000004/00000000/1", del_pc[1], del_in[1], del_err[1]);
      end
      total++; if (del_pc[2] !== 32'h8000_0008 || del_in[2] !== 32'h7FFF_FFF7 || del_err[2] !== 1'b0) begin
        bad++; $display("FAIL err_after got=%h/%h/%b exp=80000008/7ffffff7/0", del_pc[2], del_in[2], del_err[2]);
      end
    end
    err_addr = 32'h0000_0001;
  endtask

  task automatic test_wrap();
    do_reset(1, 1'b1);
    step();
    i_flush = 1'b1; i_flush_pc = 32'hFFFF_FFFC;
    step();
    i_flush = 1'b0;
    wait_acc(2, "wrap_req");
    if (acc_addr.size() >= 2) begin
      total++; if (acc_addr[0] !== 32'hFFFF_FFFC || acc_addr[1] !== 32'h0000_0000) begin
        bad++; $display("FAIL wrap_addr got=%h,%h exp=fffffffc,00000000", acc_addr[0], acc_addr[1]);
      end
    end
    wait_del(2, "wrap_del");
    if (del_pc.size() >= 2) begin
      total++; if (del_pc[0] !== 32'hFFFF_FFFC || del_in[0] !== 32'h0000_0003 || del_pc[1] !== 32'h0) begin
        bad++; $display("FAIL wrap_pc got=%h/%h,%h exp=fffffffc/00000003,00000000", del_pc[0], del_in[0], del_pc[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_drain();
    test_flush_collide();
    test_err();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
